// File: rtl/irq_aggregator_pkg.sv
// Shared definitions for the interrupt aggregator: register offsets, FSM states and
// the "no source" vector code.
package irq_aggregator_pkg;

    localparam logic [1:0] OffPending = 2'd0;
    localparam logic [1:0] OffMask    = 2'd1;
    localparam logic [1:0] OffMode    = 2'd2;
    localparam logic [1:0] OffVector  = 2'd3;

    localparam logic [7:0] VecNone = 8'hFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRaised  = 2'd1,
        StService = 2'd2
    } irq_state_e;

    // Index of the lowest set bit, VecNone when nothing is set.
    function automatic logic [7:0] lowest_index(input logic [7:0] req);
        logic [7:0] idx;
        idx = VecNone;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 8'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// Processor-side control signals and peripheral request/retire lines of the aggregator.
// The tristate data bus is a plain port on the block so it resolves at the module boundary.
interface irq_aggregator_if #(
    parameter int unsigned NumSrc = 8
);

    logic [7:0]        bus_addr;
    logic              bus_we;
    logic [NumSrc-1:0] src_irq;
    logic [NumSrc-1:0] src_ack;
    logic              irq_raise;
    logic              irq_ack;

    modport master (
        output bus_addr,
        output bus_we,
        output src_irq,
        output irq_ack,
        input  src_ack,
        input  irq_raise
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  src_irq,
        input  irq_ack,
        output src_ack,
        output irq_raise
    );

endinterface

// File: rtl/irq_src_capture.sv
// Per-source request latch: level or rising-edge capture into a pending bit that the
// processor retires with write-one-to-clear. A new capture beats a clear in the same cycle.
module irq_src_capture (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic clr_i,
    output logic pending_o
);

    logic src_q;
    logic pend_q;
    logic set;

    // Capture condition for this cycle.
    always_comb begin
        set = edge_mode_i ? (src_i & ~src_q) : src_i;
    end

    // Edge history follows the input even in reset, so a source already high when reset
    // releases is not seen as a rising edge.
    always_ff @(posedge clk_i) begin
        src_q <= src_i;
    end

    // Pending latch: set has priority over the W1C clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= set | (pend_q & ~clr_i);
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: merges NumSrc requests onto one raise/ack pair towards the
// processor, with mask, mode, pending and vector registers on the 8-bit memory bus.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int unsigned NumSrc   = 8,
    parameter logic [7:0]  BaseAddr = 8'hE0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    inout  wire [7:0]      bus_data_io,
    irq_aggregator_if.slave bus
);

    logic [7:0]        offset;
    logic              hit;
    logic              wr_en;
    logic              rd_en;
    logic [1:0]        reg_sel;
    logic [NumSrc-1:0] wdata;
    logic [NumSrc-1:0] w1c;
    logic [NumSrc-1:0] pending;
    logic [NumSrc-1:0] active;
    logic [7:0]        top_idx;
    logic              retire;

    logic [NumSrc-1:0] mask_q;
    logic [NumSrc-1:0] mode_q;
    logic [7:0]        vector_q, vector_d;
    irq_state_e        state_q, state_d;
    logic [NumSrc-1:0] src_ack_q, src_ack_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              drive_q;

    // Modular subtraction keeps the decode correct for any base address.
    assign offset  = bus.bus_addr - BaseAddr;
    assign hit     = offset < 8'd4;
    assign wr_en   = hit & bus.bus_we;
    assign rd_en   = hit & ~bus.bus_we;
    assign reg_sel = offset[1:0];
    assign wdata   = bus_data_io[NumSrc-1:0];
    assign w1c     = (wr_en && reg_sel == OffPending) ? wdata : '0;
    assign active  = pending & mask_q;
    assign top_idx = lowest_index(8'(active));
    assign retire  = wr_en && (reg_sel == OffPending) && bus_data_io[vector_q[2:0]];

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        irq_src_capture u_capture (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .src_i       (bus.src_irq[i]),
            .edge_mode_i (mode_q[i]),
            .clr_i       (w1c[i]),
            .pending_o   (pending[i])
        );
    end

    // Service FSM: next state, vector lock and retire pulse.
    always_comb begin
        state_d   = state_q;
        vector_d  = vector_q;
        src_ack_d = '0;
        unique case (state_q)
            StIdle: begin
                if (|active) begin
                    state_d = StRaised;
                end
            end
            StRaised: begin
                // Locks VecNone if every active source went away before the ack.
                if (bus.irq_ack) begin
                    vector_d = top_idx;
                    state_d  = StService;
                end
            end
            StService: begin
                if (vector_q == VecNone) begin
                    state_d = StIdle;
                end else if (retire) begin
                    for (int i = 0; i < NumSrc; i++) begin
                        src_ack_d[i] = (vector_q == 8'(i));
                    end
                    vector_d = VecNone;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Register read mux, sampled from pre-edge values.
    always_comb begin
        rdata_d = '0;
        unique case (reg_sel)
            OffPending: rdata_d = 8'(pending);
            OffMask:    rdata_d = 8'(mask_q);
            OffMode:    rdata_d = 8'(mode_q);
            OffVector:  rdata_d = vector_q;
            default:    rdata_d = '0;
        endcase
    end

    // FSM, vector and retire pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            vector_q  <= VecNone;
            src_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            vector_q  <= vector_d;
            src_ack_q <= src_ack_d;
        end
    end

    // Configuration registers and registered read data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mask_q  <= '0;
            mode_q  <= '0;
            rdata_q <= '0;
            drive_q <= 1'b0;
        end else begin
            if (wr_en && reg_sel == OffMask) begin
                mask_q <= wdata;
            end
            if (wr_en && reg_sel == OffMode) begin
                mode_q <= wdata;
            end
            rdata_q <= rdata_d;
            drive_q <= rd_en;
        end
    end

    assign bus.irq_raise = (state_q == StRaised);
    assign bus.src_ack   = src_ack_q;
    assign bus_data_io   = drive_q ? rdata_q : 8'hzz;

endmodule

// File: tb/tb_irq_aggregator.sv
// Bench for irq_aggregator: directed scenarios with literal expectations, then random
// traffic, all shadowed by a behavioural model compared on every falling edge.
module tb_irq_aggregator;

    localparam int unsigned NumSrc = 8;
    localparam logic [7:0]  Base   = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] bus_data;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_wdata = 8'h00;
    logic       chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    assign bus_data = tb_drive ? tb_wdata : 8'hzz;

    irq_aggregator_if #(.NumSrc(NumSrc)) bus_if ();

    irq_aggregator #(
        .NumSrc   (NumSrc),
        .BaseAddr (Base)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus_data_io (bus_data),
        .bus         (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = quiet, 1 = requesting, 2 = being serviced.
    bit [7:0] m_pend, m_mask, m_mode, m_prev, m_ack, m_rdata;
    bit [7:0] m_vec = 8'hFF;
    bit       m_rd;
    int       m_phase;

    always @(posedge clk) begin
        int       off;
        bit       hit, wr, rd;
        bit [7:0] act, src, set, clr;
        off = int'(bus_if.bus_addr) - int'(Base);
        hit = (off >= 0) && (off < 4);
        wr  = hit && bus_if.bus_we;
        rd  = hit && !bus_if.bus_we;
        src = bus_if.src_irq;
        if (!rst_n) begin
            m_pend = 0; m_mask = 0; m_mode = 0; m_prev = src;
            m_vec = 8'hFF; m_phase = 0; m_ack = 0; m_rd = 0;
        end else begin
            m_rd = rd;
            if (rd) begin
                case (off)
                    0: m_rdata = m_pend;
                    1: m_rdata = m_mask;
                    2: m_rdata = m_mode;
                    default: m_rdata = m_vec;
                endcase
            end
            act   = m_pend & m_mask;
            m_ack = 0;
            case (m_phase)
                0: if (act != 0) m_phase = 1;
                1: if (bus_if.irq_ack) begin
                    m_vec = 8'hFF;
                    for (int i = NumSrc - 1; i >= 0; i--) if (act[i]) m_vec = 8'(i);
                    m_phase = 2;
                end
                default: if (m_vec == 8'hFF) m_phase = 0;
                    else if (wr && off == 0 && tb_wdata[m_vec[2:0]]) begin
                        m_ack   = 8'd1 << m_vec;
                        m_vec   = 8'hFF;
                        m_phase = 0;
                    end
            endcase
            set    = (m_mode & src & ~m_prev) | (~m_mode & src);
            clr    = (wr && off == 0) ? tb_wdata : 8'h00;
            m_pend = set | (m_pend & ~clr);
            m_prev = src;
            if (wr && off == 1) m_mask = tb_wdata;
            if (wr && off == 2) m_mode = tb_wdata;
        end
    end

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("raise", 32'(bus_if.irq_raise), 32'(m_phase == 1));
            check("src_ack", 32'(bus_if.src_ack), 32'(m_ack));
            if (m_rd) begin
                check("rdata", 32'(bus_data), 32'(m_rdata));
            end else if (!tb_drive) begin
                checks++;
                if (bus_data !== 8'hzz) begin
                    errors++;
                    $display("FAIL bus_z: got %0h expected zz at %0t", bus_data, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input int off, output logic [7:0] data);
        bus_if.bus_addr = Base + 8'(off);
        bus_if.bus_we   = 1'b0;
        cyc();
        bus_if.bus_addr = 8'h00;
        data = bus_data;
        cyc();
    endtask

    task automatic bus_write(input int off, input logic [7:0] d);
        bus_if.bus_addr = Base + 8'(off);
        bus_if.bus_we   = 1'b1;
        tb_wdata        = d;
        tb_drive        = 1'b1;
        cyc();
        bus_if.bus_addr = 8'h00;
        bus_if.bus_we   = 1'b0;
        tb_drive        = 1'b0;
    endtask

    task automatic read_check(input string name, input int off, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(off, d);
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic pulse_ack();
        bus_if.irq_ack = 1'b1;
        cyc();
        bus_if.irq_ack = 1'b0;
    endtask

    task automatic wait_raise(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (bus_if.irq_raise) break;
            cyc();
        end
        check(name, 32'(bus_if.irq_raise), 32'd1);
    endtask

    initial begin
        logic [7:0] addr;
        bit         we, prev_rd;
        bus_if.bus_addr = 8'h00;
        bus_if.bus_we   = 1'b0;
        bus_if.src_irq  = '0;
        bus_if.irq_ack  = 1'b0;

        // 1 Reset values
        rst_n = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("reset_raise", 32'(bus_if.irq_raise), 32'd0);
        read_check("reset_pending", 0, 8'h00);
        read_check("reset_mask", 1, 8'h00);
        read_check("reset_mode", 2, 8'h00);
        read_check("reset_vector", 3, 8'hFF);

        // 2 Level path with exact raise latency
        bus_write(1, 8'h04);
        bus_if.src_irq = 8'h04;
        cyc();
        check("level_raise_n1", 32'(bus_if.irq_raise), 32'd0);
        cyc();
        check("level_raise_n2", 32'(bus_if.irq_raise), 32'd1);
        pulse_ack();
        bus_if.src_irq = 8'h00;
        read_check("level_vector", 3, 8'h02);
        bus_write(0, 8'h04);
        check("level_src_ack", 32'(bus_if.src_ack), 32'h04);
        cyc();
        check("level_src_ack_end", 32'(bus_if.src_ack), 32'h00);
        check("level_raise_after", 32'(bus_if.irq_raise), 32'd0);
        read_check("level_vector_none", 3, 8'hFF);

        // 3 Priority between two simultaneous edges
        bus_write(1, 8'hFF);
        bus_write(2, 8'hFF);
        bus_if.src_irq = 8'h22;
        cyc();
        bus_if.src_irq = 8'h00;
        wait_raise(4, "prio_raise1");
        pulse_ack();
        read_check("prio_vector1", 3, 8'h01);
        bus_write(0, 8'h02);
        check("prio_src_ack1", 32'(bus_if.src_ack), 32'h02);
        wait_raise(4, "prio_raise2");
        pulse_ack();
        read_check("prio_vector2", 3, 8'h05);
        bus_write(0, 8'h20);
        check("prio_src_ack2", 32'(bus_if.src_ack), 32'h20);

        // 4 Masked capture, then unmask
        bus_write(1, 8'h00);
        bus_if.src_irq = 8'h08;
        cyc();
        bus_if.src_irq = 8'h00;
        cyc(); cyc();
        check("mask_raise_off", 32'(bus_if.irq_raise), 32'd0);
        read_check("mask_pending", 0, 8'h08);
        bus_write(1, 8'h08);
        wait_raise(2, "mask_raise_on");
        pulse_ack();
        read_check("mask_vector", 3, 8'h03);
        bus_write(0, 8'h08);

        // 5 Set beats W1C in the same cycle
        bus_write(1, 8'h00);
        bus_if.src_irq = 8'h01;
        cyc();
        bus_if.src_irq = 8'h00;
        cyc();
        bus_if.src_irq = 8'h01;
        bus_write(0, 8'h01);
        bus_if.src_irq = 8'h00;
        read_check("collision_pending", 0, 8'h01);
        bus_write(0, 8'h01);
        read_check("collision_cleared", 0, 8'h00);

        // 6 Reset during service
        bus_write(2, 8'h00);
        bus_write(1, 8'h04);
        bus_if.src_irq = 8'h04;
        wait_raise(4, "rst_raise");
        pulse_ack();
        read_check("rst_vector_pre", 3, 8'h02);
        rst_n = 1'b0;
        bus_if.src_irq = 8'h00;
        cyc();
        check("rst_src_ack", 32'(bus_if.src_ack), 32'h00);
        check("rst_raise_low", 32'(bus_if.irq_raise), 32'd0);
        cyc();
        rst_n = 1'b1;
        read_check("rst_pending", 0, 8'h00);
        read_check("rst_mask", 1, 8'h00);
        read_check("rst_mode", 2, 8'h00);
        read_check("rst_vector", 3, 8'hFF);

        // Random traffic against the model
        prev_rd = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) bus_if.src_irq = 8'($urandom);
            bus_if.irq_ack = ($urandom_range(0, 5) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : Base + 8'($urandom_range(0, 3));
            we   = !prev_rd && ($urandom_range(0, 1) == 1);
            bus_if.bus_addr = addr;
            bus_if.bus_we   = we;
            tb_wdata        = 8'($urandom);
            tb_drive        = we;
            rst_n           = ($urandom_range(0, 699) != 0);
            prev_rd         = !we && (addr >= Base) && (addr <= Base + 8'd3);
            cyc();
        end
        bus_if.bus_addr = 8'h00;
        bus_if.bus_we   = 1'b0;
        bus_if.irq_ack  = 1'b0;
        tb_drive        = 1'b0;
        rst_n           = 1'b1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
